// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: bubble word, base opcodes and fetch FSM states.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_STALL,
        ST_FLUSH
    } fetch_state_t;

endpackage

// File: rtl/reg_field_decode.sv
// Extracts rs1/rs2/rsd from an instruction, zeroing fields the format does not use.
// Only bits [24:0] carry opcode and register fields, so the upper bits are not taken.
module reg_field_decode
    import riscv_pkg::*;
(
    input  logic [24:0] instruction,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rsd
);

    logic [6:0] opcode;
    assign opcode = instruction[6:0];

    // Raw field positions first, then clear the ones the opcode leaves undefined.
    always_comb begin
        rsd = instruction[11:7];
        rs1 = instruction[19:15];
        rs2 = instruction[24:20];
        case (opcode)
            OPC_STORE, OPC_BRANCH: rsd = 5'd0;
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                rs1 = 5'd0;
                rs2 = 5'd0;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: rs2 = 5'd0;
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register: drives a synchronous imem, handles
// redirect, squash and load-use stall, and registers decoded register fields.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcEnableSignal,
    input  logic [31:0] branchTarget,
    input  logic        nopSignal,
    input  logic        loadEnableSignal,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] instruction,
    output logic [31:0] pcOut,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rsd,
    output logic        valid
);

    fetch_state_t state, state_next;

    // fetch_pc is the address being requested now; req_pc is the address whose
    // data is on imemData this cycle (always fetch_pc - 4 outside BOOT/FLUSH entry).
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] req_pc, req_pc_next;
    logic [31:0] skid, skid_next;
    logic [31:0] instr_next, pc_next;
    logic        valid_next;
    logic [31:0] redirect_pc;
    logic [4:0]  dec_rs1, dec_rs2, dec_rsd;

    assign redirect_pc = branchTarget & 32'hFFFF_FFFC;
    assign imemAddr    = fetch_pc;

    // Next-state and next IF/ID contents; priority redirect > squash > stall.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        skid_next     = skid;
        instr_next    = instruction;
        pc_next       = pcOut;
        valid_next    = valid;
        case (state)
            ST_BOOT: begin
                instr_next    = NOP_INSTR;
                pc_next       = 32'd0;
                valid_next    = 1'b0;
                req_pc_next   = fetch_pc;
                fetch_pc_next = fetch_pc + 32'd4;
                state_next    = ST_RUN;
            end
            ST_FLUSH: begin
                // The word arriving now belongs to the abandoned path.
                instr_next = NOP_INSTR;
                pc_next    = 32'd0;
                valid_next = 1'b0;
                if (pcEnableSignal) begin
                    fetch_pc_next = redirect_pc;
                end else begin
                    req_pc_next   = fetch_pc;
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = ST_RUN;
                end
            end
            ST_RUN, ST_STALL: begin
                if (pcEnableSignal) begin
                    instr_next    = NOP_INSTR;
                    pc_next       = 32'd0;
                    valid_next    = 1'b0;
                    fetch_pc_next = redirect_pc;
                    state_next    = ST_FLUSH;
                end else if (nopSignal) begin
                    instr_next    = NOP_INSTR;
                    pc_next       = 32'd0;
                    valid_next    = 1'b0;
                    req_pc_next   = fetch_pc;
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = ST_RUN;
                end else if (loadEnableSignal) begin
                    // Park the arriving word; the held fetch_pc re-reads the next one.
                    if (state == ST_RUN) begin
                        skid_next = imemData;
                    end
                    state_next = ST_STALL;
                end else begin
                    instr_next    = (state == ST_STALL) ? skid : imemData;
                    pc_next       = req_pc;
                    valid_next    = 1'b1;
                    req_pc_next   = fetch_pc;
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = ST_RUN;
                end
            end
            default: state_next = ST_BOOT;
        endcase
    end

    reg_field_decode u_decode (
        .instruction (instr_next[24:0]),
        .rs1         (dec_rs1),
        .rs2         (dec_rs2),
        .rsd         (dec_rsd)
    );

    // State, PCs and IF/ID register (fields registered alongside the word).
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            instruction <= NOP_INSTR;
            pcOut       <= 32'd0;
            valid       <= 1'b0;
            rs1         <= 5'd0;
            rs2         <= 5'd0;
            rsd         <= 5'd0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            req_pc      <= req_pc_next;
            instruction <= instr_next;
            pcOut       <= pc_next;
            valid       <= valid_next;
            rs1         <= valid_next ? dec_rs1 : 5'd0;
            rs2         <= valid_next ? dec_rs2 : 5'd0;
            rsd         <= valid_next ? dec_rsd : 5'd0;
        end
    end

    // Skid word is pure data; a stale value is never consumed after reset.
    always_ff @(posedge clk) begin
        skid <= skid_next;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a stream-level model predicts IF/ID each cycle.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcEnableSignal = 1'b0;
    logic [31:0] branchTarget = 32'd0;
    logic        nopSignal = 1'b0;
    logic        loadEnableSignal = 1'b0;
    logic [31:0] imemAddr;
    logic [31:0] imemData = 32'd0;
    logic [31:0] instruction;
    logic [31:0] pcOut;
    logic [4:0]  rs1, rs2, rsd;
    logic        valid;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .pcEnableSignal   (pcEnableSignal),
        .branchTarget     (branchTarget),
        .nopSignal        (nopSignal),
        .loadEnableSignal (loadEnableSignal),
        .imemAddr         (imemAddr),
        .imemData         (imemData),
        .instruction      (instruction),
        .pcOut            (pcOut),
        .rs1              (rs1),
        .rs2              (rs2),
        .rsd              (rsd),
        .valid            (valid)
    );

    always #5 clk = ~clk;

    // Synchronous memory, 64 words aliased over the address space.
    logic [31:0] mem [64];
    always @(posedge clk) imemData <= mem[imemAddr[7:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        vld;
        logic        chk_pc;
        logic        chk_addr;
        logic [31:0] addr;
        logic [4:0]  e_rs1, e_rs2, e_rsd;
    } exp_t;

    exp_t q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    string phase = "reset";

    // Reference model: the next address to deliver plus the boot/flush bubble phases.
    logic [31:0] m_instr = 32'h13;
    logic [31:0] m_pc = 32'd0;
    logic        m_valid = 1'b0;
    logic [31:0] m_next = 32'd0;
    bit          m_boot = 1'b0;
    bit          m_flush = 1'b0;

    function automatic logic [14:0] exp_fields(input logic [31:0] w);
        logic [6:0] op;
        logic [4:0] f1, f2, fd;
        op = w[6:0];
        fd = w[11:7];
        f1 = w[19:15];
        f2 = w[24:20];
        if (op == 7'h23 || op == 7'h63) fd = 5'd0;
        if (op == 7'h37 || op == 7'h17 || op == 7'h6F) f1 = 5'd0;
        if (op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67 ||
            op == 7'h03 || op == 7'h13) f2 = 5'd0;
        return {f1, f2, fd};
    endfunction

    task automatic step(input bit r, input bit pe, input bit np, input bit ld,
                        input logic [31:0] tgt);
        exp_t e;
        logic [14:0] f;
        rst = r;
        pcEnableSignal = pe;
        nopSignal = np;
        loadEnableSignal = ld;
        branchTarget = tgt;
        e.chk_addr = 1'b0;
        e.addr = 32'd0;
        if (r) begin
            m_instr = 32'h13; m_pc = 32'd0; m_valid = 1'b0;
            m_next = 32'd0; m_boot = 1'b1; m_flush = 1'b0;
            e.chk_addr = 1'b1; e.addr = 32'd0;
        end else if (m_boot) begin
            m_instr = 32'h13; m_valid = 1'b0; m_boot = 1'b0;
        end else if (pe) begin
            m_instr = 32'h13; m_valid = 1'b0;
            m_next = tgt & 32'hFFFF_FFFC; m_flush = 1'b1;
            e.chk_addr = 1'b1; e.addr = m_next;
        end else if (m_flush) begin
            m_instr = 32'h13; m_valid = 1'b0; m_flush = 1'b0;
        end else if (np) begin
            m_instr = 32'h13; m_valid = 1'b0; m_next = m_next + 32'd4;
        end else if (!ld) begin
            m_instr = mem[m_next[7:2]]; m_pc = m_next; m_valid = 1'b1;
            m_next = m_next + 32'd4;
        end
        f = m_valid ? exp_fields(m_instr) : 15'd0;
        e.due = cyc + 1;
        e.name = phase;
        e.instr = m_instr;
        e.pc = m_pc;
        e.vld = m_valid;
        e.chk_pc = m_valid | r;
        e.e_rs1 = f[14:10];
        e.e_rs2 = f[9:5];
        e.e_rsd = f[4:0];
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Monitor: compare every due expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t e;
        bit ok;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            ok = (instruction === e.instr) && (valid === e.vld) &&
                 (rs1 === e.e_rs1) && (rs2 === e.e_rs2) && (rsd === e.e_rsd) &&
                 (!e.chk_pc || pcOut === e.pc) &&
                 (!e.chk_addr || imemAddr === e.addr);
            chk_cnt++;
            if (ok) pass_cnt++;
            else $display("FAIL %s cyc=%0d got instr=%h pc=%h v=%b rs1=%0d rs2=%0d rsd=%0d addr=%h want instr=%h pc=%h v=%b rs1=%0d rs2=%0d rsd=%0d addr=%h",
                          e.name, cyc, instruction, pcOut, valid, rs1, rs2, rsd, imemAddr,
                          e.instr, e.pc, e.vld, e.e_rs1, e.e_rs2, e.e_rsd, e.addr);
        end
    end

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    initial begin
        logic [31:0] tmp;
        int unsigned rr;
        bit r, pe, np, ld;
        mem[0] = 32'h00500093;
        mem[1] = 32'h002081B3;
        mem[2] = 32'h0020A023;
        mem[3] = 32'h008000EF;
        mem[4] = 32'h000012B7;
        for (int i = 5; i < 64; i++) begin
            tmp = $urandom();
            mem[i] = {tmp[31:7], ops[$urandom_range(0, 8)]};
        end
        @(posedge clk);
        #1;

        phase = "reset_seq";
        do_reset();
        idle(8);

        phase = "redirect";
        do_reset();
        idle(5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h42);
        idle(5);

        phase = "stall1";
        do_reset();
        idle(4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        idle(4);

        phase = "stall2";
        do_reset();
        idle(4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        idle(4);

        phase = "prio_all";
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0008);
        idle(4);

        phase = "prio_nop_ld";
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        idle(4);

        phase = "wrap";
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
        idle(5);

        phase = "rst_in_stall";
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        idle(4);

        phase = "rst_in_flush";
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        idle(4);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            rr = $urandom_range(0, 99);
            r  = (rr == 0);
            pe = ($urandom_range(0, 99) < 10);
            np = ($urandom_range(0, 99) < 10);
            ld = ($urandom_range(0, 99) < 25);
            step(r, pe, np, ld, $urandom());
        end
        idle(3);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain got %0d pending entries want 0", q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
